// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned HDR_BYTES = 4;
   localparam int unsigned CNT_W     = 2;

   typedef enum logic [1:0] {
      S_LEN  = 2'd0,
      S_DATA = 2'd1,
      S_RUN  = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   typedef struct packed {
      logic              en;
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] data;
   } mem_wr_t;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Big-endian 4-byte assembler; flags the byte that completes a word.
module program_loader_byte_assembler
   import program_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   output logic [WORD_W-1:0] word_c,
   output logic              word_valid_c
);

   logic [WORD_W-BYTE_W-1:0] shreg;
   logic [CNT_W-1:0]         byte_cnt;

   // Only the three older bytes are stored; the fourth is taken straight from the input.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg    <= '0;
         byte_cnt <= '0;
      end else if (byte_valid) begin
         shreg    <= {shreg[WORD_W-2*BYTE_W-1:0], byte_data};
         byte_cnt <= byte_cnt + CNT_W'(1);
      end
   end

   assign word_c       = {shreg, byte_data};
   assign word_valid_c = byte_valid && (byte_cnt == CNT_W'(HDR_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Boot sequencer: loads a UART image into memory with the CPU held in reset, then hands over the write port.
module program_loader
   import program_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 1024,
   parameter int unsigned IDX_W     = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        cpu_mem_write,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_reset,
   output logic        load_done,
   output logic        load_error
);

   state_t            state;
   logic [WORD_W-1:0] len;
   logic [IDX_W-1:0]  idx;
   mem_wr_t           wr_q;
   logic [WORD_W-1:0] word_c;
   logic              word_valid_c;
   logic              loading_c;

   assign loading_c = (state == S_LEN) || (state == S_DATA);

   // One assembler serves both the length header and the data words.
   program_loader_byte_assembler u_asm (
      .clk          (clk),
      .reset        (reset),
      .byte_valid   (rx_valid && loading_c),
      .byte_data    (rx_data),
      .word_c       (word_c),
      .word_valid_c (word_valid_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_LEN;
         len        <= '0;
         idx        <= '0;
         wr_q       <= '0;
         cpu_reset  <= 1'b1;
         load_done  <= 1'b0;
         load_error <= 1'b0;
      end else begin
         wr_q.en    <= 1'b0;
         // Status trails the state by one cycle so the final loader write clears the port first.
         cpu_reset  <= (state != S_RUN);
         load_done  <= (state == S_RUN);
         load_error <= (state == S_ERR);
         case (state)
            S_LEN: begin
               if (word_valid_c) begin
                  len <= word_c;
                  idx <= '0;
                  if (word_c == '0)
                     state <= S_RUN;
                  else if (word_c > WORD_W'(MAX_WORDS))
                     state <= S_ERR;
                  else
                     state <= S_DATA;
               end
            end
            S_DATA: begin
               if (word_valid_c) begin
                  wr_q.en   <= 1'b1;
                  wr_q.addr <= BASE_ADDR + (WORD_W'(idx) << 2);
                  wr_q.data <= word_c;
                  idx       <= idx + IDX_W'(1);
                  if (WORD_W'(idx) == len - WORD_W'(1))
                     state <= S_RUN;
               end
            end
            default: ;
         endcase
      end
   end

   // Port ownership follows load_done, which rises only after the last loader pulse.
   assign mem_write = load_done ? cpu_mem_write : wr_q.en;
   assign mem_addr  = load_done ? cpu_addr      : wr_q.addr;
   assign mem_wdata = load_done ? cpu_wdata     : wr_q.data;

endmodule
